// File: rtl/ip_codma_mem_slave_pkg.sv
// Shared types and helpers for the CODMA memory-slave responder.
// Burst-size encoding, beat decoding and the responder state enum.
package ip_codma_mem_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] SIZE_1DW = 4'h0;
  localparam logic [3:0] SIZE_2DW = 4'h1;
  localparam logic [3:0] SIZE_4DW = 4'h2;

  typedef enum logic [2:0] {
    IDLE,
    GWAIT,
    GRANT,
    RWAIT,
    RDATA,
    WDATA,
    ERR
  } mem_slave_state_t;

  // Zero beats marks an unsupported size encoding.
  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    logic [2:0] beats;
    case (size)
      SIZE_1DW: beats = 3'd1;
      SIZE_2DW: beats = 3'd2;
      SIZE_4DW: beats = 3'd4;
      default:  beats = 3'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ip_codma_mem_slave_if.sv
// CODMA mem_interface bus: address phase, read beats, write beats, error.
// The slave modport is the responder side, master is the requester side.
interface mem_interface;
  import ip_codma_mem_pkg::*;

  logic              read;
  logic              write;
  logic [31:0]       addr;
  logic [3:0]        size;
  logic              grant;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic [DATA_W-1:0] write_data;
  logic              write_valid;
  logic              error;

  modport slave (
    input  read, write, addr, size, write_data, write_valid,
    output grant, read_data, read_valid, error
  );

  modport master (
    output read, write, addr, size, write_data, write_valid,
    input  grant, read_data, read_valid, error
  );

endinterface

// File: rtl/ip_codma_mem_slave_sram.sv
// Single-port DEPTH_DW x DATA_W SRAM with a one-cycle registered read.
// Only the read output register is reset; array contents persist.
module ip_codma_sram #(
  parameter int DEPTH_DW = 256,
  parameter int DATA_W   = 64,
  parameter int AW       = $clog2(DEPTH_DW)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_DW];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  // Output holds its last value while re is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/ip_codma_mem_slave.sv
// CODMA memory-slave responder: answers mem_interface bursts out of an
// internal 64-bit SRAM with programmable grant/read wait states.
module ip_codma_mem_slave
  import ip_codma_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_DW   = 256,
  parameter int          GRANT_WAIT = 0,
  parameter int          READ_WAIT  = 0
) (
  input  logic  clock,
  input  logic  reset_n,
  mem_interface.slave bus
);

  localparam int         AW      = $clog2(DEPTH_DW);
  localparam logic [3:0] GW_LAST = 4'(GRANT_WAIT - 1);
  localparam logic [3:0] RW_LAST = 4'(READ_WAIT - 1);

  mem_slave_state_t  state;
  logic [AW-1:0]     idx_r;
  logic [2:0]        beats_r;
  logic              is_read_r;
  logic              err_r;
  logic [3:0]        wait_cnt;
  logic [2:0]        ptr;
  logic              grant_r;
  logic              error_r;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;

  logic [31:0]       req_off;
  logic [31:0]       req_idx;
  logic [2:0]        req_beats;
  logic [32:0]       req_end;
  logic              req_err;
  logic              rd_en;
  logic              wr_en;
  logic [AW-1:0]     mem_addr;

  // Request decode, evaluated on the sampling edge in IDLE.
  always_comb begin
    req_off   = bus.addr - BASE_ADDR;
    req_idx   = req_off >> 3;
    req_beats = size_to_beats(bus.size);
    req_end   = {1'b0, req_idx} + {30'b0, req_beats};
    req_err   = (bus.read && bus.write)
             || (bus.addr[2:0] != 3'b000)
             || (req_beats == 3'd0)
             || (bus.addr < BASE_ADDR)
             || (req_end > 33'(DEPTH_DW));
  end

  // Read address is issued one cycle ahead of each read_valid beat.
  always_comb begin
    rd_en = 1'b0;
    case (state)
      GRANT:   rd_en = is_read_r && !err_r && (READ_WAIT == 0);
      RWAIT:   rd_en = (wait_cnt == RW_LAST);
      RDATA:   rd_en = (ptr != beats_r);
      default: rd_en = 1'b0;
    endcase
    wr_en    = (state == WDATA) && bus.write_valid;
    mem_addr = idx_r + AW'(ptr);
  end

  ip_codma_sram #(
    .DEPTH_DW (DEPTH_DW),
    .DATA_W   (DATA_W),
    .AW       (AW)
  ) u_sram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wr_en),
    .re      (rd_en),
    .addr    (mem_addr),
    .wdata   (bus.write_data),
    .rdata   (rd_data_p1)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx_r     <= '0;
      beats_r   <= '0;
      is_read_r <= 1'b0;
      err_r     <= 1'b0;
      wait_cnt  <= '0;
      ptr       <= '0;
      grant_r   <= 1'b0;
      error_r   <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      grant_r   <= 1'b0;
      error_r   <= 1'b0;
      rd_vld_p1 <= rd_en;
      if (rd_en || wr_en) ptr <= ptr + 3'd1;

      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            idx_r     <= req_idx[AW-1:0];
            beats_r   <= req_beats;
            is_read_r <= bus.read;
            err_r     <= req_err;
            ptr       <= '0;
            wait_cnt  <= '0;
            if (GRANT_WAIT == 0) begin
              grant_r <= 1'b1;
              state   <= GRANT;
            end else begin
              state   <= GWAIT;
            end
          end
        end
        GWAIT: begin
          if (wait_cnt == GW_LAST) begin
            wait_cnt <= '0;
            grant_r  <= 1'b1;
            state    <= GRANT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        GRANT: begin
          if (err_r) begin
            error_r <= 1'b1;
            state   <= ERR;
          end else if (is_read_r) begin
            state   <= (READ_WAIT == 0) ? RDATA : RWAIT;
          end else begin
            state   <= WDATA;
          end
        end
        RWAIT: begin
          if (wait_cnt == RW_LAST) begin
            wait_cnt <= '0;
            state    <= RDATA;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RDATA: begin
          if (!rd_en) state <= IDLE;
        end
        WDATA: begin
          if (wr_en && (ptr == beats_r - 3'd1)) state <= IDLE;
        end
        ERR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant_r;
  assign bus.error      = error_r;
  assign bus.read_valid = rd_vld_p1;
  assign bus.read_data  = rd_data_p1;

endmodule

// File: tb/tb_ip_codma_mem_slave.sv
// Directed bench for ip_codma_mem_slave: one zero-wait instance and one
// instance with grant/read wait states, driven as a bus master.
module tb_ip_codma_mem_slave;
  import ip_codma_mem_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  mem_interface bus0 ();
  mem_interface bus1 ();

  ip_codma_mem_slave #(
    .BASE_ADDR (32'h0), .DEPTH_DW (256), .GRANT_WAIT (0), .READ_WAIT (0)
  ) dut0 (
    .clock (clock), .reset_n (reset_n), .bus (bus0.slave)
  );

  ip_codma_mem_slave #(
    .BASE_ADDR (32'h0), .DEPTH_DW (256), .GRANT_WAIT (3), .READ_WAIT (2)
  ) dut1 (
    .clock (clock), .reset_n (reset_n), .bus (bus1.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_grant0(input string tag, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus0.grant && lat < 40);
    check_eq($sformatf("%s_grant_lat", tag), 64'(lat), 64'(exp_lat));
    bus0.read  = 1'b0;
    bus0.write = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [3:0] sz,
                          input int n_exp, input logic [63:0] e0, input logic [63:0] e1,
                          input logic [63:0] e2, input logic [63:0] e3, input int exp_err);
    logic [63:0] exp_d [4];
    int nv = 0, ne = 0, first = -1, last = -1;
    exp_d = '{e0, e1, e2, e3};
    @(negedge clock);
    bus0.read = 1'b1; bus0.write = 1'b0; bus0.addr = a; bus0.size = sz;
    wait_grant0(tag, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus0.error) ne++;
      if (bus0.read_valid) begin
        if (first < 0) first = i;
        last = i;
        if (nv < 4) check_eq($sformatf("%s_d%0d", tag, nv), bus0.read_data, exp_d[nv]);
        nv++;
      end
    end
    check_eq($sformatf("%s_beats", tag), 64'(nv), 64'(n_exp));
    check_eq($sformatf("%s_errors", tag), 64'(ne), 64'(exp_err));
    if (n_exp > 0) begin
      check_eq($sformatf("%s_first", tag), 64'(first), 64'd0);
      check_eq($sformatf("%s_span", tag), 64'(last - first + 1), 64'(n_exp));
    end
  endtask

  task automatic bus_write(input string tag, input logic [31:0] a, input logic [3:0] sz,
                           input int n, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3,
                           input int gap_at, input int exp_err);
    logic [63:0] d [4];
    int ne = 0;
    d = '{d0, d1, d2, d3};
    @(negedge clock);
    bus0.write = 1'b1; bus0.read = 1'b0; bus0.addr = a; bus0.size = sz;
    wait_grant0(tag, 1);
    // A beat offered during the grant cycle must be ignored.
    bus0.write_valid = 1'b1;
    bus0.write_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        @(negedge clock);
        if (bus0.error) ne++;
        bus0.write_valid = 1'b0;
      end
      @(negedge clock);
      if (bus0.error) ne++;
      bus0.write_valid = 1'b1;
      bus0.write_data  = d[k];
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus0.error) ne++;
      bus0.write_valid = 1'b0;
    end
    check_eq($sformatf("%s_errors", tag), 64'(ne), 64'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bus0.read = 0; bus0.write = 0; bus0.addr = 0; bus0.size = 0;
    bus0.write_data = 0; bus0.write_valid = 0;
    bus1.read = 0; bus1.write = 0; bus1.addr = 0; bus1.size = 0;
    bus1.write_data = 0; bus1.write_valid = 0;
    repeat (3) @(negedge clock);

    check_eq("rst_grant0", 64'(bus0.grant), 64'd0);
    check_eq("rst_rvalid0", 64'(bus0.read_valid), 64'd0);
    check_eq("rst_error0", 64'(bus0.error), 64'd0);
    check_eq("rst_rdata0", bus0.read_data, 64'd0);
    check_eq("rst_grant1", 64'(bus1.grant), 64'd0);
    check_eq("rst_rdata1", bus1.read_data, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single beat write then read back.
    bus_write("w1", 32'h10, SIZE_1DW, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, -1, 0);
    bus_read("r1", 32'h10, SIZE_1DW, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);

    // Four-beat burst with a write_valid gap before the third beat.
    bus_write("w4", 32'h40, SIZE_4DW, 4, 64'd1, 64'd2, 64'd3, 64'd4, 2, 0);
    bus_read("r4", 32'h40, SIZE_4DW, 4, 64'd1, 64'd2, 64'd3, 64'd4, 0);
    bus_read("r2", 32'h48, SIZE_2DW, 2, 64'd2, 64'd3, 0, 0, 0);

    // Misaligned and unsupported-size reads.
    bus_read("r_misal", 32'h44, SIZE_1DW, 0, 0, 0, 0, 0, 1);
    bus_read("r_size3", 32'h40, 4'h3, 0, 0, 0, 0, 0, 1);

    // Top-of-array burst overrun must not disturb the last two words.
    bus_write("w_top", 32'h7F0, SIZE_2DW, 2, 64'hAAAA_0000_0000_00FE, 64'h5555_0000_0000_00FF, 0, 0, -1, 0);
    bus_write("w_ovr", 32'h7F0, SIZE_4DW, 4, 64'h11, 64'h22, 64'h33, 64'h44, -1, 1);
    bus_read("r_top", 32'h7F0, SIZE_2DW, 2, 64'hAAAA_0000_0000_00FE, 64'h5555_0000_0000_00FF, 0, 0, 0);
    bus_read("r_last", 32'h7F8, SIZE_1DW, 1, 64'h5555_0000_0000_00FF, 0, 0, 0, 0);
    bus_read("r_ovr2", 32'h7F8, SIZE_2DW, 0, 0, 0, 0, 0, 1);

    // Wait-state instance: grant 4 cycles after request, data 3 after grant.
    @(negedge clock);
    bus1.read = 1'b1; bus1.addr = 32'h0; bus1.size = SIZE_1DW;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!bus1.grant && lat < 40);
    check_eq("ws_grant_lat", 64'(lat), 64'd4);
    bus1.read = 1'b0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!bus1.read_valid && lat < 40);
    check_eq("ws_rvalid_lat", 64'(lat), 64'd3);
    @(negedge clock);
    check_eq("ws_rvalid_drop", 64'(bus1.read_valid), 64'd0);
    check_eq("ws_error", 64'(bus1.error), 64'd0);

    // Reset during the second beat of a four-beat read.
    @(negedge clock);
    bus0.read = 1'b1; bus0.addr = 32'h40; bus0.size = SIZE_4DW;
    wait_grant0("rst_mid", 1);
    @(negedge clock);
    check_eq("rst_mid_b0", bus0.read_data, 64'd1);
    @(negedge clock);
    check_eq("rst_mid_b1", bus0.read_data, 64'd2);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_grant", 64'(bus0.grant), 64'd0);
    check_eq("rst_mid_rvalid", 64'(bus0.read_valid), 64'd0);
    check_eq("rst_mid_error", 64'(bus0.error), 64'd0);
    check_eq("rst_mid_rdata", bus0.read_data, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bus_read("post_rst", 32'h10, SIZE_1DW, 1, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ip_codma_mem_slave.md
Name: ip_codma_mem_slave

Overview:
- Synthesizable memory-slave responder: the target end of the CODMA mem_interface bus.
- Answers read/write requests from the CODMA master (or a testbench master) out of an internal 64-bit-wide SRAM.
- Supports single, 2-beat and 4-beat double-word bursts, programmable grant and read wait states, and bus errors.
- Used as on-chip scratch memory and as the reference target in block- and system-level benches.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first double-word; must be 8-byte aligned.
- DEPTH_DW, 256: number of 64-bit words (power of two, 16..4096).
- GRANT_WAIT, 0: extra idle cycles between request sampled and grant (0..15).
- READ_WAIT, 0: extra cycles between grant and the first read_valid beat (0..15).

Ports:
- clock  input  1  bus clock; all logic is posedge.
- reset_n  input  1  asynchronous active-low reset.
- read  input  1  address phase: read request, held until grant.
- write  input  1  address phase: write request, held until grant.
- addr  input  32  byte address, held until grant.
- size  input  4  burst size, held until grant.
- grant  output  1  one-cycle pulse ending the address phase.
- read_data  output  64  read beat data.
- read_valid  output  1  read_data valid this cycle.
- write_data  input  64  write beat data.
- write_valid  input  1  write_data valid this cycle.
- error  output  1  one-cycle transaction-failed pulse.

All bus ports are bound through the mem_interface slave modport.

Behaviour:
- Reset (async assert, sync release):
  - grant, read_valid and error = 0; read_data = 64'h0; FSM = IDLE; counters = 0.
  - SRAM contents are not reset.
- Size encoding:
  - 4'h0 = 1 beat, 4'h1 = 2 beats, 4'h2 = 4 beats.
  - Any other value is unsupported.
- Word index = (addr - BASE_ADDR) >> 3, computed at 32 bits. Beat k uses index + k. There is no wrap-around.
- Error conditions, checked on the request-sampling edge:
  - read && write both high;
  - addr[2:0] != 0;
  - unsupported size;
  - addr < BASE_ADDR;
  - index + beats > DEPTH_DW, i.e. the last beat falls outside the array.
- FSM states: IDLE, GWAIT, GRANT, RWAIT, RDATA, WDATA, ERR.
  - IDLE: on a rising edge with read or write high, capture addr, size, direction and the error flag. Go to GWAIT if GRANT_WAIT > 0, else GRANT.
  - GWAIT: count GRANT_WAIT cycles, then go to GRANT.
  - GRANT: grant = 1 for exactly one cycle. Master may drop the request next cycle. Next state is ERR if errored, else RWAIT/RDATA for a read, else WDATA.
  - RWAIT: count READ_WAIT cycles, then go to RDATA.
  - RDATA: read_valid = 1 on consecutive cycles, one beat per word, ascending index. Drop to 0 after the last beat and return to IDLE. read_data holds its last value when read_valid is 0.
  - WDATA: each cycle with write_valid = 1 writes write_data to index + beat_count and increments beat_count. Gaps (write_valid = 0) are allowed. After the final beat, return to IDLE. write_valid during the GRANT cycle is ignored.
  - ERR: error = 1 for one cycle. No read_valid is produced and no SRAM write occurs; write_valid beats are ignored. Return to IDLE.
- Latency with GRANT_WAIT = 0 and READ_WAIT = 0:
  - request sampled at edge N;
  - grant high in cycle N+1;
  - first read_valid in cycle N+2.
- Requests presented while not in IDLE are not sampled; the master keeps holding them.
- Back-to-back: a request held in the cycle after a transaction completes is sampled then (one IDLE cycle minimum).
- Reset mid-transaction: FSM returns to IDLE immediately. A partially written burst keeps the beats already written.

Decomposition:
- Package ip_codma_mem_pkg:
  - size encoding constants SIZE_1DW, SIZE_2DW, SIZE_4DW;
  - function size_to_beats returning 0 for unsupported sizes;
  - state enum mem_slave_state_t.
- Sub-module ip_codma_sram: DEPTH_DW x 64 single-port SRAM with one-cycle synchronous read and a write enable. Its one-cycle read latency is absorbed by issuing the read address in the cycle before each RDATA beat.

Test Plan:
1. Write addr 32'h10, size 4'h0, data 64'hDEAD_BEEF_0123_4567; then read 32'h10 -> grant one cycle after the request; read_valid exactly one cycle, read_data 64'hDEAD_BEEF_0123_4567; error stays 0.
2. 4-beat write at 32'h40 with data 1,2,3,4 and one write_valid gap; then 4-beat read -> read_valid on 4 consecutive cycles with 1,2,3,4.
3. Read with addr 32'h44 (misaligned), then with size 4'h3 -> each gets grant, then error for one cycle; read_valid never asserts.
4. DEPTH_DW = 256, 4-beat write at 32'h7F0 (index 254) -> error; words 254 and 255 unchanged, confirmed by a 2-beat read returning prior contents.
5. GRANT_WAIT = 3, READ_WAIT = 2, single read -> grant 4 cycles after request sample; read_valid 3 cycles after grant.
6. Assert reset_n low during the second beat of a 4-beat read -> grant, read_valid and error are 0 immediately; after release, a new read is granted normally.
